// File: rtl/uart_pkg.sv
// Shared encodings and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // 27 MHz / 115200 baud, minus one for a count-to-zero divider.
  localparam int UART_DIVIDER = 233;
  localparam int UART_DATA_W  = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after last_owner, wrapping.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  int idx;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    idx        = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_owner) + k) % N_REQ;
      if (!win_valid && req[idx]) begin
        win_valid       = 1'b1;
        win_idx         = IDX_W'(idx);
        win_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that owns the uart_tx start/busy handshake.
// Handshake: a requester byte is consumed in a cycle where req_valid[i] && req_ready[i]
// at the rising clk edge; tx_start stays high with tx_data stable until tx_busy is seen.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic                    idle,
  output logic [1:0]              dbg_state
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t            state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  last_owner;
  logic              last_q;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;

  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_owner (last_owner),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .win_valid  (pick_valid)
  );

  // grant is one-hot while owned, so this mux selects exactly the owner's lane.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = (state == ST_SEND) ? (req_valid & grant) : '0;
  assign idle      = (state == ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= IDX_W'(N_REQ - 1);
      last_q     <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant <= pick_onehot;
            owner <= pick_idx;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          // A silent owner keeps the grant: packets are never split.
          if (sel_valid) begin
            tx_data  <= sel_data;
            tx_start <= 1'b1;
            last_q   <= sel_last;
            state    <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            tx_start <= 1'b0;
            state    <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_q) begin
              grant      <= '0;
              last_owner <= owner;
              state      <= ST_IDLE;
            end else begin
              state <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx busy model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N_REQ  = 2;
  localparam int DATA_W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;
  logic [N_REQ-1:0]        req_last = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        grant;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_busy;
  logic                    idle;
  logic [1:0]              dbg_state;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .idle      (idle),
    .dbg_state (dbg_state)
  );

  // checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // uart_tx model: busy rises one cycle after start (plus busy_extra), high for 10 cycles
  int busy_extra = 0;
  int cnt = 0;
  int dly = 0;
  logic armed = 1'b0;
  logic busy = 1'b0;
  int n_model = 0;
  assign tx_busy = busy;

  always @(posedge clk) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      armed <= 1'b0;
      cnt   <= 0;
      dly   <= 0;
    end else if (busy) begin
      cnt <= cnt - 1;
      if (cnt == 1) busy <= 1'b0;
    end else if (armed) begin
      if (dly == 0) begin
        busy  <= 1'b1;
        cnt   <= 10;
        armed <= 1'b0;
      end else begin
        dly <= dly - 1;
      end
    end else if (tx_start) begin
      n_model <= n_model + 1;
      if (busy_extra == 0) begin
        busy <= 1'b1;
        cnt  <= 10;
      end else begin
        armed <= 1'b1;
        dly   <= busy_extra - 1;
      end
    end
  end

  // requester drivers: each queue entry is {last, data}
  logic [8:0] src0_q[$];
  logic [8:0] src1_q[$];
  logic [N_REQ-1:0] acc = '0;

  always @(negedge clk) acc = req_ready;

  always @(posedge clk) begin
    #1;
    if (acc[0] && src0_q.size() > 0) void'(src0_q.pop_front());
    if (acc[1] && src1_q.size() > 0) void'(src1_q.pop_front());
    req_valid[0]   = (src0_q.size() > 0);
    req_valid[1]   = (src1_q.size() > 0);
    req_data[7:0]  = (src0_q.size() > 0) ? src0_q[0][7:0] : 8'h00;
    req_data[15:8] = (src1_q.size() > 0) ? src1_q[0][7:0] : 8'h00;
    req_last[0]    = (src0_q.size() > 0) ? src0_q[0][8] : 1'b0;
    req_last[1]    = (src1_q.size() > 0) ? src1_q[0][8] : 1'b0;
  end

  // scoreboard: every new tx_start must carry the next expected {grant, byte}
  logic [9:0] exp_q[$];
  logic       prev_start = 1'b0;
  logic [7:0] cap = '0;
  int         start_len = 0;
  int         n_tx = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0;
    end else begin
      if (tx_start && !prev_start) begin
        cap       = tx_data;
        start_len = 0;
        n_tx++;
        if (exp_q.size() == 0) check("unexpected_byte", {grant, tx_data}, 32'h0);
        else check("byte", {grant, tx_data}, exp_q.pop_front());
      end
      if (tx_start) begin
        start_len++;
        if (prev_start) check("data_hold", tx_data, cap);
      end
      prev_start = tx_start;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    busy_extra = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int t = 0;
    while (!(exp_q.size() == 0 && src0_q.size() == 0 && src1_q.size() == 0
             && idle && !busy) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, (t < budget), 1);
  endtask

  initial begin
    int t;
    int bad_grant;
    int bad_start;
    int bad_ready;
    int tx_before;
    int model_before;

    // reset state
    do_reset();
    check("rst_grant", grant, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_idle", idle, 1);
    check("rst_ready", req_ready, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // 1: single packet, latency and release timing
    exp_q.push_back({2'b01, 8'h48});
    exp_q.push_back({2'b01, 8'h69});
    src0_q.push_back({1'b0, 8'h48});
    src0_q.push_back({1'b1, 8'h69});
    @(negedge clk);
    check("t1_c0_grant", grant, 0);
    check("t1_c0_ready", req_ready, 0);
    @(negedge clk);
    check("t1_c1_grant", grant, 2'b01);
    check("t1_c1_ready", req_ready, 2'b01);
    check("t1_c1_start", tx_start, 0);
    @(negedge clk);
    check("t1_c2_start", tx_start, 1);
    check("t1_c2_data", tx_data, 8'h48);
    t = 0;
    while (!(n_tx == 2 && !busy && !tx_start) && t < 100) begin
      @(negedge clk);
      check("t1_grant_held", grant, 2'b01);
      t++;
    end
    check("t1_busy_fall_timeout", (t < 100), 1);
    check("t1_wait_done_idle", idle, 0);
    @(negedge clk);
    check("t1_release_grant", grant, 0);
    check("t1_release_idle", idle, 1);
    check("t1_start_len", start_len, 2);
    wait_drain("t1_drain", 50);

    // 2: contention after reset, 3-byte packets, no interleaving
    do_reset();
    for (int i = 0; i < 3; i++) begin
      src0_q.push_back({(i == 2), 8'hA0 + 8'(i)});
      src1_q.push_back({(i == 2), 8'hB0 + 8'(i)});
    end
    for (int i = 0; i < 3; i++) exp_q.push_back({2'b01, 8'hA0 + 8'(i)});
    for (int i = 0; i < 3; i++) exp_q.push_back({2'b10, 8'hB0 + 8'(i)});
    wait_drain("t2_drain", 200);

    // 3: fairness with back-to-back one-byte packets (pointer last on 1)
    for (int i = 0; i < 2; i++) begin
      src0_q.push_back({1'b1, 8'hC0 + 8'(i)});
      src1_q.push_back({1'b1, 8'hD0 + 8'(i)});
      exp_q.push_back({2'b01, 8'hC0 + 8'(i)});
      exp_q.push_back({2'b10, 8'hD0 + 8'(i)});
    end
    wait_drain("t3_drain", 200);

    // 4: owner stall while the other requester waits
    src0_q.push_back({1'b0, 8'hE0});
    src1_q.push_back({1'b1, 8'hF0});
    exp_q.push_back({2'b01, 8'hE0});
    exp_q.push_back({2'b01, 8'hE1});
    exp_q.push_back({2'b10, 8'hF0});
    repeat (20) @(negedge clk);
    check("t4_in_send", dbg_state, ST_SEND);
    bad_grant = 0;
    bad_start = 0;
    bad_ready = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (grant !== 2'b01) bad_grant++;
      if (tx_start !== 1'b0) bad_start++;
      if (req_ready[1] !== 1'b0) bad_ready++;
    end
    check("t4_stall_grant", bad_grant, 0);
    check("t4_stall_start", bad_start, 0);
    check("t4_stall_ready1", bad_ready, 0);
    check("t4_exp_left", exp_q.size(), 2);
    src0_q.push_back({1'b1, 8'hE1});
    wait_drain("t4_drain", 200);

    // 5: slow busy, start held until busy seen, one byte only
    busy_extra   = 5;
    tx_before    = n_tx;
    model_before = n_model;
    src0_q.push_back({1'b1, 8'h5A});
    exp_q.push_back({2'b01, 8'h5A});
    wait_drain("t5_drain", 100);
    check("t5_start_len", start_len, 7);
    check("t5_one_byte", n_tx - tx_before, 1);
    check("t5_model_one", n_model - model_before, 1);
    busy_extra = 0;

    // 6: reset in WAIT_DONE mid-packet, then fresh contention
    src0_q.push_back({1'b0, 8'h11});
    src0_q.push_back({1'b1, 8'h22});
    exp_q.push_back({2'b01, 8'h11});
    t = 0;
    while (dbg_state != ST_WAIT_DONE && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("t6_reach_wait_done", (t < 50), 1);
    check("t6_exp_used", exp_q.size(), 0);
    rst_n = 1'b0;
    src0_q.delete();
    src1_q.delete();
    @(negedge clk);
    check("t6_rst_grant", grant, 0);
    check("t6_rst_start", tx_start, 0);
    check("t6_rst_idle", idle, 1);
    @(negedge clk);
    rst_n = 1'b1;
    src0_q.push_back({1'b1, 8'h33});
    src1_q.push_back({1'b1, 8'h44});
    exp_q.push_back({2'b01, 8'h33});
    exp_q.push_back({2'b10, 8'h44});
    wait_drain("t6_drain", 100);

    check("final_exp_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
